pipe_mem: RTL and testbench
===========================

# pipe_mem

Memory stage of the dual-issue RV64 pipeline: the consumer of the execute stage's `mempack_t` memory request (ena, write, funct3, addr, wdata). It turns one load or store per op into a valid/ready request on the data bus, with byte strobes and lane-shifted store data. For loads it aligns and sign- or zero-extends the returned doubleword. It holds `mem_stall` high until the access has completed.

## Interface
Parameters:
- `DATA_WIDTH`, 64: bus and register data width; fixed at 64 for RV64.
- `ADDR_WIDTH`, 64: address width.

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  clock.
- `rst`  in  1  synchronous active-high reset.
- `mem_mempack`  in  mempack_t  request from execute. Held stable by upstream while `mem_stall`=1.
- `pipe_hold`  in  1  stall from elsewhere in the pipeline; the current op must not retire.
- `mem_stall`  out  1  stall to the pipeline.
- `load_valid`  out  1  load result valid in DONE.
- `load_data`  out  DATA_WIDTH  extended load result.
- `misalign`  out  1  misaligned-access flag; exists only under the macro.
- `dbus_req_valid`  out  1  bus request valid.
- `dbus_req_ready`  in  1  bus accepts the request.
- `dbus_req_write`  out  1  1 = store.
- `dbus_req_addr`  out  ADDR_WIDTH  address with bits [2:0] forced to 0.
- `dbus_req_wdata`  out  DATA_WIDTH  lane-shifted store data.
- `dbus_req_strb`  out  8  byte strobes.
- `dbus_resp_valid`  in  1  read data valid.
- `dbus_resp_rdata`  in  DATA_WIDTH  read doubleword.

## Operation
- FSM states: IDLE, REQ, WAIT, DONE.
- IDLE, `ena`=0: `mem_stall`=0. No bus activity.
- IDLE, `ena`=1: `mem_stall`=1 combinationally. Latch write, funct3, addr and wdata, compute strobes and shifted data, then go to REQ.
- REQ: `dbus_req_valid`=1 and request fields stable until the handshake.
  - Handshake (valid & ready), store: go to DONE. A store completes on acceptance.
  - Handshake, load: go to WAIT.
- WAIT: on `dbus_resp_valid`, capture the extended data and go to DONE.
- DONE:
  - `mem_stall`=0.
  - `load_valid`=1 for loads.
  - With `pipe_hold`=0: go to IDLE. With `pipe_hold`=1: stay in DONE, outputs unchanged.
- Size from funct3[1:0]: 0=byte, 1=half, 2=word, 3=double. funct3[2]=1 means zero-extend (LBU/LHU/LWU).
- Byte offset `off` = addr[2:0].
  - Strobes: (2^size − 1) << off, truncated to 8 bits.
  - Store data: wdata << (8·off), truncated.
- Load result: (rdata >> 8·off), masked to the access size, then sign- or zero-extended to 64 bits.
- `dbus_resp_valid` outside WAIT is ignored.
- `mem_stall`=1 in every state except IDLE with `ena`=0, and DONE.

## Timing
- Reset values:
  - State IDLE.
  - `dbus_req_valid`=0, `load_valid`=0, `misalign`=0.
  - `load_data`=0, `dbus_req_*`=0.
- All bus outputs come from registers.
- Store latency, ready already high: 3 cycles (IDLE, REQ, DONE).
- Load latency, ready high and response one cycle after acceptance: 4 cycles (IDLE, REQ, WAIT, DONE).
- Once `dbus_req_valid` is asserted it never drops before ready.
- Reset mid-operation returns to IDLE and drops `dbus_req_valid` at the reset edge. The bus is reset in the same cycle, so no stale response arrives.
- `load_data` holds its value from DONE until the next load completes.

## Configuration
- `MEM_MISALIGN_CHECK_EN` defined:
  - An access with off mod 2^size ≠ 0 issues no bus request and goes IDLE → DONE.
  - In DONE: `misalign`=1, `load_valid`=0, `load_data`=0.
- Macro undefined:
  - No `misalign` port; no check is made.
  - Bytes beyond lane 7 are dropped by strobe truncation.
  - Loads return the truncated, extended bytes.

## Structure
- The state enum `mem_state_t` and the size encodings belong in `def_cpu.svh`, next to `mempack_t`.
- The load/store funct3 constants belong in `def_inst.svh`.
- One combinational sub-module, `lsu_align`, handles:
  - store side: strobe and data shifting;
  - load side: shift, mask and extend.
- `pipe_mem` itself keeps the FSM, the request registers and the response capture.

## Test plan
- SD, addr 0x1000, wdata 0x1122334455667788, ready high → req addr 0x1000, strb 0xFF; `mem_stall` high for 2 cycles, low in DONE.
- SB, addr 0x1003, wdata 0xAB → strb 0x08, wdata 0xAB000000, req addr 0x1000.
- LB, addr 0x2005, rdata 0x0000_80FF_0000_0000, response 3 cycles after acceptance → `load_data` 0xFFFF_FFFF_FFFF_FF80; `load_valid` 1 for one cycle.
- LWU, addr 0x2004, rdata 0x8765_4321_xxxx_xxxx, with `pipe_hold`=1 for 2 cycles in DONE → `load_data` 0x0000_0000_8765_4321; DONE held 3 cycles; no second request.
- `dbus_req_ready` low for 5 cycles → req fields and valid stable throughout; no state advance; `rst` asserted in cycle 3 → valid 0 and IDLE next cycle.
- With `MEM_MISALIGN_CHECK_EN`, LW at 0x3002 → no `dbus_req_valid`; `misalign`=1 in DONE; `load_data` 0.

Source files
------------

// File: rtl/pipe_mem_pkg.sv
// rtl/pipe_mem_pkg.sv - memory-stage types, size encodings and load/store funct3 constants
package pipe_mem_pkg;

  typedef struct packed {
    logic        ena;
    logic        write;
    logic [2:0]  funct3;
    logic [63:0] addr;
    logic [63:0] wdata;
  } mempack_t;

  typedef enum logic [1:0] {
    MEM_IDLE,
    MEM_REQ,
    MEM_WAIT,
    MEM_DONE
  } mem_state_t;

  localparam logic [1:0] SIZE_B = 2'd0;
  localparam logic [1:0] SIZE_H = 2'd1;
  localparam logic [1:0] SIZE_W = 2'd2;
  localparam logic [1:0] SIZE_D = 2'd3;

  localparam logic [2:0] F3_LB  = 3'd0;
  localparam logic [2:0] F3_LH  = 3'd1;
  localparam logic [2:0] F3_LW  = 3'd2;
  localparam logic [2:0] F3_LD  = 3'd3;
  localparam logic [2:0] F3_LBU = 3'd4;
  localparam logic [2:0] F3_LHU = 3'd5;
  localparam logic [2:0] F3_LWU = 3'd6;
  localparam logic [2:0] F3_SB  = 3'd0;
  localparam logic [2:0] F3_SH  = 3'd1;
  localparam logic [2:0] F3_SW  = 3'd2;
  localparam logic [2:0] F3_SD  = 3'd3;

  // An access is misaligned when the byte offset is not a multiple of its size.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [2:0] off);
    case (size)
      SIZE_H:  return off[0];
      SIZE_W:  return |off[1:0];
      SIZE_D:  return |off;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/pipe_mem_lsu_align.sv
// rtl/pipe_mem_lsu_align.sv - store strobe/lane shifting and load shift/mask/extend
module lsu_align
  import pipe_mem_pkg::*;
(
  input  logic [1:0]  st_size,
  input  logic [2:0]  st_off,
  input  logic [63:0] st_wdata,
  output logic [7:0]  st_strb,
  output logic [63:0] st_wdata_sh,
  input  logic [2:0]  ld_funct3,
  input  logic [2:0]  ld_off,
  input  logic [63:0] ld_rdata,
  output logic [63:0] ld_data
);

  logic [7:0]  size_mask;
  logic [63:0] ld_sh;
  logic        ld_sext;

  // Lanes past byte 7 fall off the top of the 8-bit strobe.
  always_comb begin
    case (st_size)
      SIZE_B:  size_mask = 8'h01;
      SIZE_H:  size_mask = 8'h03;
      SIZE_W:  size_mask = 8'h0F;
      default: size_mask = 8'hFF;
    endcase
    st_strb     = size_mask << st_off;
    st_wdata_sh = st_wdata << {st_off, 3'b000};
  end

  always_comb begin
    ld_sh   = ld_rdata >> {ld_off, 3'b000};
    ld_sext = ~ld_funct3[2];
    case (ld_funct3[1:0])
      SIZE_B:  ld_data = {{56{ld_sext & ld_sh[7]}}, ld_sh[7:0]};
      SIZE_H:  ld_data = {{48{ld_sext & ld_sh[15]}}, ld_sh[15:0]};
      SIZE_W:  ld_data = {{32{ld_sext & ld_sh[31]}}, ld_sh[31:0]};
      default: ld_data = ld_sh;
    endcase
  end

endmodule

// File: rtl/pipe_mem.sv
// rtl/pipe_mem.sv - RV64 memory stage: FSM, bus request registers, load capture
// Optional misaligned-access trap enabled by MEM_MISALIGN_CHECK_EN.
module pipe_mem
  import pipe_mem_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  mempack_t              mem_mempack,
  input  logic                  pipe_hold,
  output logic                  mem_stall,
  output logic                  load_valid,
  output logic [DATA_WIDTH-1:0] load_data,
`ifdef MEM_MISALIGN_CHECK_EN
  output logic                  misalign,
`endif
  output logic                  dbus_req_valid,
  input  logic                  dbus_req_ready,
  output logic                  dbus_req_write,
  output logic [ADDR_WIDTH-1:0] dbus_req_addr,
  output logic [DATA_WIDTH-1:0] dbus_req_wdata,
  output logic [7:0]            dbus_req_strb,
  input  logic                  dbus_resp_valid,
  input  logic [DATA_WIDTH-1:0] dbus_resp_rdata
);

  mem_state_t            state_q, state_d;
  logic                  write_q;
  logic [2:0]            funct3_q;
  logic [2:0]            off_q;
  logic                  req_valid_q;
  logic [ADDR_WIDTH-1:0] req_addr_q;
  logic [DATA_WIDTH-1:0] req_wdata_q;
  logic [7:0]            req_strb_q;
  logic [DATA_WIDTH-1:0] load_data_q;
  logic                  mis_now;
  logic                  mis_q;
  logic [7:0]            st_strb;
  logic [63:0]           st_wdata_sh;
  logic [63:0]           ld_data;

  lsu_align u_align (
    .st_size     (mem_mempack.funct3[1:0]),
    .st_off      (mem_mempack.addr[2:0]),
    .st_wdata    (mem_mempack.wdata),
    .st_strb     (st_strb),
    .st_wdata_sh (st_wdata_sh),
    .ld_funct3   (funct3_q),
    .ld_off      (off_q),
    .ld_rdata    (dbus_resp_rdata),
    .ld_data     (ld_data)
  );

`ifdef MEM_MISALIGN_CHECK_EN
  assign mis_now = is_misaligned(mem_mempack.funct3[1:0], mem_mempack.addr[2:0]);
`else
  assign mis_now = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      MEM_IDLE: if (mem_mempack.ena) state_d = mis_now ? MEM_DONE : MEM_REQ;
      MEM_REQ:  if (dbus_req_ready) state_d = write_q ? MEM_DONE : MEM_WAIT;
      MEM_WAIT: if (dbus_resp_valid) state_d = MEM_DONE;
      MEM_DONE: if (!pipe_hold) state_d = MEM_IDLE;
      default:  state_d = MEM_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= MEM_IDLE;
      write_q     <= 1'b0;
      funct3_q    <= 3'd0;
      off_q       <= 3'd0;
      req_valid_q <= 1'b0;
      req_addr_q  <= '0;
      req_wdata_q <= '0;
      req_strb_q  <= 8'd0;
      load_data_q <= '0;
      mis_q       <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        MEM_IDLE: if (mem_mempack.ena) begin
          write_q     <= mem_mempack.write;
          funct3_q    <= mem_mempack.funct3;
          off_q       <= mem_mempack.addr[2:0];
          req_valid_q <= ~mis_now;
          req_addr_q  <= {mem_mempack.addr[ADDR_WIDTH-1:3], 3'b000};
          req_wdata_q <= mem_mempack.write ? st_wdata_sh : '0;
          req_strb_q  <= st_strb;
          mis_q       <= mis_now;
          if (mis_now) load_data_q <= '0;
        end
        MEM_REQ:  if (dbus_req_ready) req_valid_q <= 1'b0;
        MEM_WAIT: if (dbus_resp_valid) load_data_q <= ld_data;
        MEM_DONE: if (!pipe_hold) mis_q <= 1'b0;
        default:  ;
      endcase
    end
  end

  assign mem_stall      = !((state_q == MEM_IDLE && !mem_mempack.ena) || state_q == MEM_DONE);
  assign load_valid     = (state_q == MEM_DONE) && !write_q && !mis_q;
  assign load_data      = load_data_q;
  assign dbus_req_valid = req_valid_q;
  assign dbus_req_write = write_q;
  assign dbus_req_addr  = req_addr_q;
  assign dbus_req_wdata = req_wdata_q;
  assign dbus_req_strb  = req_strb_q;
`ifdef MEM_MISALIGN_CHECK_EN
  assign misalign       = mis_q;
`endif

endmodule

// File: tb/tb_pipe_mem.sv
// tb/tb_pipe_mem.sv - scoreboard bench for pipe_mem loads, stores, stalls and reset
module tb_pipe_mem;
  import pipe_mem_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  mempack_t    mem_mempack;
  logic        pipe_hold;
  logic        mem_stall;
  logic        load_valid;
  logic [63:0] load_data;
`ifdef MEM_MISALIGN_CHECK_EN
  logic        misalign;
`endif
  logic        dbus_req_valid;
  logic        dbus_req_ready;
  logic        dbus_req_write;
  logic [63:0] dbus_req_addr;
  logic [63:0] dbus_req_wdata;
  logic [7:0]  dbus_req_strb;
  logic        dbus_resp_valid;
  logic [63:0] dbus_resp_rdata;

  always #5 clk = ~clk;

  pipe_mem dut (
    .clk             (clk),
    .rst             (rst),
    .mem_mempack     (mem_mempack),
    .pipe_hold       (pipe_hold),
    .mem_stall       (mem_stall),
    .load_valid      (load_valid),
    .load_data       (load_data),
`ifdef MEM_MISALIGN_CHECK_EN
    .misalign        (misalign),
`endif
    .dbus_req_valid  (dbus_req_valid),
    .dbus_req_ready  (dbus_req_ready),
    .dbus_req_write  (dbus_req_write),
    .dbus_req_addr   (dbus_req_addr),
    .dbus_req_wdata  (dbus_req_wdata),
    .dbus_req_strb   (dbus_req_strb),
    .dbus_resp_valid (dbus_resp_valid),
    .dbus_resp_rdata (dbus_resp_rdata)
  );

  typedef struct {
    logic        write;
    logic [63:0] addr;
    logic [7:0]  strb;
    logic [63:0] wdata;
  } req_t;

  req_t        exp_req_q[$];
  logic [63:0] exp_ld_q[$];
  int          n_checks = 0;
  int          n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic int nbytes(input logic [2:0] f3);
    return 1 << f3[1:0];
  endfunction

  function automatic logic [7:0] m_strb(input logic [2:0] f3, input logic [63:0] addr);
    logic [7:0] s = 8'd0;
    for (int i = 0; i < nbytes(f3); i++)
      if (int'(addr[2:0]) + i < 8) s[int'(addr[2:0]) + i] = 1'b1;
    return s;
  endfunction

  function automatic logic [63:0] m_wdata(input logic [63:0] addr, input logic [63:0] wdata);
    logic [63:0] r = 64'd0;
    for (int j = 0; j < 8; j++)
      if (j >= int'(addr[2:0])) r[j*8 +: 8] = wdata[(j - int'(addr[2:0]))*8 +: 8];
    return r;
  endfunction

  function automatic logic [63:0] m_load(input logic [2:0] f3, input logic [63:0] addr,
                                         input logic [63:0] rdata);
    logic [63:0] r = 64'd0;
    int          n = nbytes(f3);
    for (int i = 0; i < n; i++)
      if (int'(addr[2:0]) + i < 8) r[i*8 +: 8] = rdata[(int'(addr[2:0]) + i)*8 +: 8];
    if (!f3[2] && r[n*8-1])
      for (int i = n; i < 8; i++) r[i*8 +: 8] = 8'hFF;
    return r;
  endfunction

  task automatic do_op(input string tag, input logic wr, input logic [2:0] f3,
                       input logic [63:0] addr, input logic [63:0] wdata, input logic [63:0] rdata,
                       input int ready_delay, input int resp_delay, input int hold);
    req_t        r;
    logic [63:0] exp_ld;
    r.write = wr;
    r.addr  = {addr[63:3], 3'b000};
    r.strb  = m_strb(f3, addr);
    r.wdata = wr ? m_wdata(addr, wdata) : 64'd0;
    exp_req_q.push_back(r);
    if (!wr) exp_ld_q.push_back(m_load(f3, addr, rdata));
    exp_ld = 64'd0;

    mem_mempack    = '{ena: 1'b1, write: wr, funct3: f3, addr: addr, wdata: wdata};
    dbus_req_ready = (ready_delay == 0);
    #1;
    check({tag, "_stall_idle"}, mem_stall, 1);
    @(negedge clk);
    r = exp_req_q.pop_front();
    check({tag, "_req_valid"}, dbus_req_valid, 1);
    check({tag, "_req_write"}, dbus_req_write, r.write);
    check({tag, "_req_addr"}, dbus_req_addr, r.addr);
    check({tag, "_req_strb"}, dbus_req_strb, r.strb);
    check({tag, "_req_wdata"}, dbus_req_wdata, r.wdata);
    check({tag, "_stall_req"}, mem_stall, 1);
    for (int i = 0; i < ready_delay; i++) begin
      dbus_resp_valid = 1'b1;
      dbus_resp_rdata = $urandom();
      @(negedge clk);
      check({tag, "_hold_valid"}, dbus_req_valid, 1);
      check({tag, "_hold_fields"}, {dbus_req_addr ^ dbus_req_wdata, dbus_req_strb},
            {r.addr ^ r.wdata, r.strb});
      check({tag, "_hold_stall"}, mem_stall, 1);
    end
    dbus_resp_valid = 1'b0;
    dbus_req_ready  = 1'b1;
    @(negedge clk);
    dbus_req_ready = 1'b0;
    check({tag, "_valid_drop"}, dbus_req_valid, 0);
    if (!wr) begin
      for (int i = 1; i < resp_delay; i++) begin
        check({tag, "_wait_stall"}, mem_stall, 1);
        @(negedge clk);
      end
      check({tag, "_wait_stall"}, mem_stall, 1);
      dbus_resp_valid = 1'b1;
      dbus_resp_rdata = rdata;
      @(negedge clk);
      dbus_resp_valid = 1'b0;
      dbus_resp_rdata = 64'hBAD0_BAD0_BAD0_BAD0;
      exp_ld = exp_ld_q.pop_front();
      check({tag, "_load_data"}, load_data, exp_ld);
    end
    check({tag, "_done_stall"}, mem_stall, 0);
    check({tag, "_load_valid"}, load_valid, !wr);
    pipe_hold = (hold > 0);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check({tag, "_held_done"}, {load_valid, mem_stall, dbus_req_valid}, {!wr, 2'b00});
    end
    pipe_hold       = 1'b0;
    mem_mempack.ena = 1'b0;
    @(negedge clk);
    check({tag, "_idle"}, {load_valid, mem_stall, dbus_req_valid}, 3'b000);
    if (!wr) check({tag, "_load_keep"}, load_data, exp_ld);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst             = 1'b1;
    mem_mempack     = '0;
    pipe_hold       = 1'b0;
    dbus_req_ready  = 1'b0;
    dbus_resp_valid = 1'b0;
    dbus_resp_rdata = 64'd0;
    repeat (2) @(negedge clk);
    check("rst_valid", dbus_req_valid, 0);
    check("rst_load_valid", load_valid, 0);
    check("rst_load_data", load_data, 0);
    check("rst_req_fields", {dbus_req_addr, dbus_req_strb, dbus_req_write}, 0);
    check("rst_req_wdata", dbus_req_wdata, 0);
    check("rst_stall", mem_stall, 0);
    rst = 1'b0;
    @(negedge clk);

    do_op("sd",  1'b1, F3_SD,  64'h1000, 64'h1122334455667788, 64'd0, 0, 1, 0);
    do_op("sb",  1'b1, F3_SB,  64'h1003, 64'hAB, 64'd0, 0, 1, 0);
    do_op("lb",  1'b0, F3_LB,  64'h2005, 64'd0, 64'h0000_80FF_0000_0000, 0, 3, 0);
    do_op("lwu", 1'b0, F3_LWU, 64'h2004, 64'd0, 64'h8765_4321_DEAD_BEEF, 0, 1, 2);
    do_op("sh",  1'b1, F3_SH,  64'h1006, 64'hFFFF_0000_0000_BEEF, 64'd0, 5, 1, 0);
    do_op("lh",  1'b0, F3_LH,  64'h2006, 64'd0, 64'h8001_0000_0000_0000, 2, 2, 0);
    do_op("lhu", 1'b0, F3_LHU, 64'h2002, 64'd0, 64'h0000_0000_F00D_0000, 0, 1, 1);
    do_op("lbu", 1'b0, F3_LBU, 64'h2007, 64'd0, 64'h9900_0000_0000_0000, 0, 1, 0);
    do_op("lw",  1'b0, F3_LW,  64'h2000, 64'd0, 64'h1234_5678_8000_0001, 0, 2, 0);
    do_op("ld",  1'b0, F3_LD,  64'h2008, 64'd0, 64'hFEDC_BA98_7654_3210, 1, 1, 0);
    do_op("sw",  1'b1, F3_SW,  64'h1004, 64'hCAFE_F00D, 64'd0, 0, 1, 0);

`ifdef MEM_MISALIGN_CHECK_EN
    mem_mempack    = '{ena: 1'b1, write: 1'b0, funct3: F3_LW, addr: 64'h3002, wdata: 64'd0};
    dbus_req_ready = 1'b1;
    @(negedge clk);
    check("mis_valid", dbus_req_valid, 0);
    check("mis_flag", misalign, 1);
    check("mis_load_valid", load_valid, 0);
    check("mis_load_data", load_data, 0);
    check("mis_stall", mem_stall, 0);
    mem_mempack.ena = 1'b0;
    dbus_req_ready  = 1'b0;
    @(negedge clk);
    check("mis_clear", {misalign, dbus_req_valid}, 2'b00);
`else
    do_op("sw_wrap", 1'b1, F3_SW, 64'h3006, 64'h4433_2211, 64'd0, 0, 1, 0);
    do_op("lw_wrap", 1'b0, F3_LW, 64'h3006, 64'd0, 64'h8899_0000_0000_0000, 0, 1, 0);
`endif

    mem_mempack    = '{ena: 1'b1, write: 1'b1, funct3: F3_SW, addr: 64'h4000, wdata: 64'h55};
    dbus_req_ready = 1'b0;
    @(negedge clk);
    check("rmid_valid", dbus_req_valid, 1);
    @(negedge clk);
    check("rmid_valid2", dbus_req_valid, 1);
    rst             = 1'b1;
    mem_mempack.ena = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    check("rmid_drop", dbus_req_valid, 0);
    check("rmid_idle", mem_stall, 0);
    @(negedge clk);
    check("rmid_quiet", dbus_req_valid, 0);
    do_op("ld_post", 1'b0, F3_LD, 64'h5000, 64'd0, 64'h0102_0304_0506_0708, 0, 1, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
